// File: rtl/keccak_obi_ctrl.sv
// keccak_obi_ctrl: OBI slave front-end that buffers the Keccak state, launches the core and captures its result.
module keccak_obi_ctrl #(
  parameter int StateWords = 50,
  parameter int AddrLsbW   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [3:0]               be_i,
  input  logic [31:0]              addr_i,
  input  logic [31:0]              wdata_i,
  output logic                     gnt_o,
  output logic                     rvalid_o,
  output logic [31:0]              rdata_o,
  output logic                     keccak_start_o,
  output logic [StateWords*32-1:0] keccak_din_o,
  input  logic [StateWords*32-1:0] keccak_dout_i,
  input  logic                     keccak_done_i,
  output logic                     intr_o
);
  localparam int AW = AddrLsbW - 2;
  localparam int IdxW = $clog2(StateWords);
  localparam logic [AW-1:0] DinEnd   = AW'(StateWords);
  localparam logic [AW-1:0] DoutBase = AW'(64);
  localparam logic [AW-1:0] DoutEnd  = AW'(64 + StateWords);
  localparam logic [AW-1:0] CtrlW    = AW'(128);
  localparam logic [AW-1:0] StatW    = AW'(129);
  typedef enum logic [1:0] {IDLE, START, BUSY} state_e;
  state_e state_q, state_d;
  logic [31:0] din_q [StateWords];
  logic [31:0] dout_q [StateWords];
  logic irq_en_q, done_q, intr_q, start_q, rvalid_q;
  logic [31:0] rdata_q, rdata_d;
  logic [AW-1:0] word;
  logic [IdxW-1:0] idx;
  logic wr, rd, din_hit, dout_hit, ctrl_hit, stat_hit, busy, done_evt, start_acc, clr;
  logic unused_addr;
  assign unused_addr = ^{addr_i[31:AddrLsbW], addr_i[1:0]};
  assign word      = addr_i[AddrLsbW-1:2];
  assign idx       = word[IdxW-1:0];
  assign wr        = req_i & we_i;
  assign rd        = req_i & ~we_i;
  assign din_hit   = word < DinEnd;
  assign dout_hit  = (word >= DoutBase) && (word < DoutEnd);
  assign ctrl_hit  = word == CtrlW;
  assign stat_hit  = word == StatW;
  assign busy      = state_q != IDLE;
  assign done_evt  = (state_q == BUSY) && keccak_done_i;
  // START only launches from IDLE, so a start racing a done in BUSY is dropped
  assign start_acc = wr && ctrl_hit && be_i[0] && wdata_i[0] && (state_q == IDLE);
  assign clr       = wr && stat_hit && be_i[0] && wdata_i[1];
  assign gnt_o          = req_i;
  assign rvalid_o       = rvalid_q;
  assign rdata_o        = rdata_q;
  assign keccak_start_o = start_q;
  assign intr_o         = intr_q;
  always_comb begin
    state_d = start_acc ? START : (state_q == START) ? BUSY : done_evt ? IDLE : state_q;
    rdata_d = !rd      ? 32'h0 :
              din_hit  ? din_q[idx] :
              dout_hit ? dout_q[idx] :
              ctrl_hit ? {30'h0, irq_en_q, 1'b0} :
              stat_hit ? {30'h0, done_q, busy} : 32'h0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      irq_en_q <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_acc;
      rvalid_q <= req_i;
      rdata_q  <= rdata_d;
      done_q   <= done_evt | (done_q & ~start_acc & ~clr);
      intr_q   <= done_q & irq_en_q;
      if (wr && ctrl_hit && be_i[0]) irq_en_q <= wdata_i[1];
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < StateWords; i++) begin
        din_q[i]  <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      if (wr && din_hit && !busy)
        for (int b = 0; b < 4; b++)
          if (be_i[b]) din_q[idx][8*b +: 8] <= wdata_i[8*b +: 8];
      if (done_evt)
        for (int i = 0; i < StateWords; i++) dout_q[i] <= keccak_dout_i[32*i +: 32];
    end
  end
  for (genvar k = 0; k < StateWords; k++) begin : g_din
    assign keccak_din_o[32*k +: 32] = din_q[k];
  end
endmodule
